// File: rtl/fp_pkg.sv
// Shared single-precision field definitions for the FP add/sub, divide and
// square-root blocks.
//   - field positions and widths of the IEEE-754 single format
//   - special encodings used by the flush/saturate paths
//   - control-state encodings for the iterative divider
package fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [7:0]  EXP_INF  = 8'hFF;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_DIV  = 2'd1;
    localparam state_t ST_NORM = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/fp_div_mant_step.sv
// One restoring-division step on the 24-bit mantissas.
// Ports:
//   rem      - current partial remainder (26b)
//   mb       - divisor mantissa with hidden bit (24b)
//   q        - quotient bits produced so far (26b)
//   rem_next - remainder after this step, already shifted left
//   q_next   - quotient with the new bit appended at the LSB
module fp_div_mant_step
    import fp_pkg::*;
(
    input  logic [25:0] rem,
    input  logic [23:0] mb,
    input  logic [25:0] q,
    output logic [25:0] rem_next,
    output logic [25:0] q_next
);

    logic [26:0] diff;
    logic        unused_bits;

    assign diff = {1'b0, rem} - {3'b000, mb};

    // rem < 2*mb always holds, so a non-negative difference fits in 25 bits
    // and the shifted remainder never overflows 26 bits.
    assign unused_bits = diff[25] ^ q[25];

    always_comb begin
        if (!diff[26]) begin
            rem_next = {diff[24:0], 1'b0};
            q_next   = {q[24:0], 1'b1};
        end else begin
            rem_next = {rem[24:0], 1'b0};
            q_next   = {q[24:0], 1'b0};
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative single-precision divider, data_o = data_iA / data_iB.
// One quotient bit per clock, fixed 28-cycle start-to-done latency.
// No denormals (exp=0 is zero), truncation rounding, exp=255 treated as normal.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start_i          - request pulse, only honoured in IDLE
//   data_iA, data_iB - dividend / divisor, captured on accept
//   busy_o           - high from the cycle after accept until DONE is left
//   done_o           - one-cycle pulse, result and flags valid
//   data_o           - quotient, held until the next result
//   dbz_o/ovf_o/unf_o - divide-by-zero / overflow / underflow flags, held
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int EXP_BIAS = 127,
    parameter int QBITS    = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] data_iA,
    input  logic [31:0] data_iB,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] data_o,
    output logic        dbz_o,
    output logic        ovf_o,
    output logic        unf_o
);

    localparam int CNT_W = $clog2(QBITS);

    state_t             state;
    logic               sign_q;
    logic [7:0]         ea_q;
    logic [7:0]         eb_q;
    logic [23:0]        mb_q;
    logic [25:0]        rem_q;
    logic [25:0]        quo_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [25:0]        rem_next;
    logic [25:0]        quo_next;

    fp_div_mant_step u_step (
        .rem      (rem_q),
        .mb       (mb_q),
        .q        (quo_q),
        .rem_next (rem_next),
        .q_next   (quo_next)
    );

    // Normalisation and special-case selection, consumed in NORM.
    logic signed [9:0]  exp_calc;
    logic [22:0]        mant_n;
    logic [31:0]        res_n;
    logic               dbz_n;
    logic               ovf_n;
    logic               unf_n;
    logic               unused_lsb;

    assign unused_lsb = quo_q[0];

    always_comb begin
        exp_calc = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                 + $signed(10'(EXP_BIAS));
        if (!quo_q[25])
            exp_calc = exp_calc - 10'sd1;
        mant_n = quo_q[25] ? quo_q[24:2] : quo_q[23:1];

        res_n = {sign_q, exp_calc[7:0], mant_n};
        dbz_n = 1'b0;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        if (eb_q == 8'd0) begin
            res_n = {sign_q, EXP_INF, 23'd0};
            dbz_n = 1'b1;
        end else if (ea_q == 8'd0) begin
            res_n = {sign_q, 31'd0};
        end else if (exp_calc >= 10'sd255) begin
            res_n = {sign_q, EXP_INF, 23'd0};
            ovf_n = 1'b1;
        end else if (exp_calc <= 10'sd0) begin
            res_n = {sign_q, 31'd0};
            unf_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            sign_q <= 1'b0;
            ea_q   <= '0;
            eb_q   <= '0;
            mb_q   <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            data_o <= '0;
            dbz_o  <= 1'b0;
            ovf_o  <= 1'b0;
            unf_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        sign_q <= data_iA[SIGN_BIT] ^ data_iB[SIGN_BIT];
                        ea_q   <= data_iA[EXP_MSB:EXP_LSB];
                        eb_q   <= data_iB[EXP_MSB:EXP_LSB];
                        mb_q   <= {1'b1, data_iB[MANT_W-1:0]};
                        rem_q  <= {2'b01, data_iA[MANT_W-1:0]};
                        quo_q  <= '0;
                        cnt_q  <= CNT_W'(QBITS - 1);
                        busy_o <= 1'b1;
                        state  <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (cnt_q == '0)
                        state <= ST_NORM;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                ST_NORM: begin
                    data_o <= res_n;
                    dbz_o  <= dbz_n;
                    ovf_o  <= ovf_n;
                    unf_o  <= unf_n;
                    done_o <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed vectors, randomized operands
// against an integer-arithmetic reference, handshake and reset-abort cases.
module tb_fp_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [31:0] data_iA;
    logic [31:0] data_iB;
    logic        busy_o;
    logic        done_o;
    logic [31:0] data_o;
    logic        dbz_o;
    logic        ovf_o;
    logic        unf_o;

    int checks   = 0;
    int failures = 0;

    fp_div_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .data_iA (data_iA),
        .data_iB (data_iB),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .data_o  (data_o),
        .dbz_o   (dbz_o),
        .ovf_o   (ovf_o),
        .unf_o   (unf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: quotient of the mantissas as an exact integer division,
    // then exponent arithmetic and the special cases in priority order.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [2:0] flags);
        logic        s;
        int          ea, eb, e;
        longint      ma, mb, q, m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        flags = 3'b000;  // {dbz, ovf, unf}
        if (eb == 0) begin
            r = {s, 8'hFF, 23'd0};
            flags = 3'b100;
        end else if (ea == 0) begin
            r = {s, 31'd0};
        end else begin
            ma = longint'({1'b1, a[22:0]});
            mb = longint'({1'b1, b[22:0]});
            q  = (ma * (64'd1 << 25)) / mb;
            if (q >= (64'd1 << 25)) begin
                e = ea - eb + 127;
                m = (q / 4) % (64'd1 << 23);
            end else begin
                e = ea - eb + 126;
                m = (q / 2) % (64'd1 << 23);
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                flags = 3'b010;
            end else if (e <= 0) begin
                r = {s, 31'd0};
                flags = 3'b001;
            end else begin
                r = {s, e[7:0], m[22:0]};
            end
        end
    endtask

    // Issues a start at the current negedge and waits (bounded) for done_o.
    // lat counts clock edges from the accepting edge to the one raising done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [2:0] flags,
                          output int lat);
        start_i = 1'b1;
        data_iA = a;
        data_iB = b;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r     = data_o;
        flags = {dbz_o, ovf_o, unf_o};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        data_iA = '0;
        data_iB = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o, data_o, dbz_o, ovf_o, unf_o} !== 37'd0) begin
            failures++;
            $display("FAIL reset: outputs=%h required 0",
                     {busy_o, done_o, data_o, dbz_o, ovf_o, unf_o});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'h40C00000, 32'h3F800000, 32'hBF800000,
                                32'h00000000, 32'h3F800000, 32'h7F000000};
        logic [31:0] vb [6] = '{32'h40000000, 32'h40400000, 32'h3F000000,
                                32'h40000000, 32'h00000000, 32'h00800000};
        logic [31:0] er [6] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0000000,
                                32'h00000000, 32'h7F800000, 32'h7F800000};
        logic [2:0]  ef [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010};
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            logic [31:0] a, b, xr;
            logic [2:0]  xf;
            if (i < 6) begin
                a = va[i]; b = vb[i]; xr = er[i]; xf = ef[i];
            end else begin
                a = 32'h00800000; b = 32'h7F000000; xr = 32'h0; xf = 3'b001;
            end
            run_op(a, b, r, f, lat);
            checks++;
            if (r !== xr || f !== xf) begin
                failures++;
                $display("FAIL directed[%0d] %h/%h: got %h flags=%b required %h flags=%b",
                         i, a, b, r, f, xr, xf);
            end
            checks++;
            if (lat !== 28) begin
                failures++;
                $display("FAIL latency[%0d]: got %0d required 28", i, lat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, xr;
        logic [2:0]  f, xf;
        int          lat;
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 9) == 0) a[30:23] = 8'd0;
            if ($urandom_range(0, 9) == 0) b[30:23] = 8'd0;
            model(a, b, xr, xf);
            run_op(a, b, r, f, lat);
            checks++;
            if (r !== xr || f !== xf || lat !== 28) begin
                failures++;
                $display("FAIL random[%0d] %h/%h: got %h flags=%b lat=%0d required %h flags=%b lat=28",
                         i, a, b, r, f, lat, xr, xf);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] xr;
        logic [2:0]  xf;
        int          lat;
        model(32'h40C00000, 32'h40000000, xr, xf);
        start_i = 1'b1;
        data_iA = 32'h40C00000;
        data_iB = 32'h40000000;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_accept: got %b required 1", busy_o);
        end
        lat = 1;
        repeat (4) begin @(negedge clk); lat++; end
        start_i = 1'b1;
        data_iA = 32'h3F800000;
        data_iB = 32'h40400000;
        @(negedge clk);
        lat++;
        start_i = 1'b0;
        while (!done_o && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (data_o !== xr || {dbz_o, ovf_o, unf_o} !== xf || lat !== 28) begin
            failures++;
            $display("FAIL ignore_start: got %h lat=%0d required %h lat=28", data_o, lat, xr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (data_o !== xr || done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL hold_after_done: data=%h done=%b busy=%b required %h 0 0",
                     data_o, done_o, busy_o, xr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, xr;
        logic [2:0]  f, xf;
        int          lat;
        @(negedge clk);
        run_op(32'hBF800000, 32'h3F000000, r, f, lat);
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: done still %b required 0", done_o);
        end
        model(32'h3F800000, 32'h40400000, xr, xf);
        run_op(32'h3F800000, 32'h40400000, r, f, lat);
        checks++;
        if (r !== xr || f !== xf || lat !== 28) begin
            failures++;
            $display("FAIL back_to_back: got %h lat=%0d required %h lat=28", r, lat, xr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r, xr;
        logic [2:0]  f, xf;
        int          lat;
        bit          saw_done;
        start_i = 1'b1;
        data_iA = 32'h40C00000;
        data_iB = 32'h40000000;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_o, done_o, data_o, dbz_o, ovf_o, unf_o} !== 37'd0) begin
            failures++;
            $display("FAIL reset_mid_op: outputs=%h required 0",
                     {busy_o, done_o, data_o, dbz_o, ovf_o, unf_o});
        end
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: done seen=%b required 0", saw_done);
        end
        model(32'h7F000000, 32'h3F000000, xr, xf);
        run_op(32'h7F000000, 32'h3F000000, r, f, lat);
        checks++;
        if (r !== xr || f !== xf || lat !== 28) begin
            failures++;
            $display("FAIL after_reset: got %h flags=%b lat=%0d required %h flags=%b",
                     r, f, lat, xr, xf);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
